// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette geometry, clear value, FSM encoding and
// the palette mirror-canonicalisation rule.
package ppu_pkg;

  localparam int PAL_ENTRIES = 32;
  localparam int PAL_ENTRY_W = 8;
  localparam int PAL_ADDR_W  = 5;
  localparam logic [PAL_ENTRY_W-1:0] PAL_INIT_VALUE = 8'h0F;

  typedef enum logic {
    PAL_INIT = 1'b0,
    PAL_IDLE = 1'b1
  } pal_state_e;

  // $3F10/$3F14/$3F18/$3F1C are mirrors of $3F00/$3F04/$3F08/$3F0C.
  function automatic logic [PAL_ADDR_W-1:0] pal_canon(input logic [PAL_ADDR_W-1:0] addr);
    pal_canon = (addr[4] && (addr[1:0] == 2'b00)) ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/palette_mirror_map.sv
// Maps a palette address to its canonical index and flags addresses that
// belong to a mirrored pair.
module palette_mirror_map
  import ppu_pkg::*;
(
  input  logic [PAL_ADDR_W-1:0] addr,
  output logic [PAL_ADDR_W-1:0] canon_idx,
  output logic                  alias_hit
);

  assign canon_idx = pal_canon(addr);
  assign alias_hit = (addr[1:0] == 2'b00);

endmodule

// File: rtl/ppu_palette_ram.sv
// Palette RAM: live array written by the CPU, shadow copy refreshed on
// frame_sync and presented as background/sprite colour buses.
module ppu_palette_ram
  import ppu_pkg::*;
#(
  parameter logic [PAL_ENTRY_W-1:0] INIT_VALUE = PAL_INIT_VALUE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [PAL_ADDR_W-1:0]  wr_addr,
  input  logic [PAL_ENTRY_W-1:0] wr_data,
  output logic                   wr_ack,
  input  logic                   rd_en,
  input  logic [PAL_ADDR_W-1:0]  rd_addr,
  output logic [PAL_ENTRY_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   frame_sync,
  output logic                   ready,
  output logic [127:0]           background_colors,
  output logic [127:0]           sprite_colors
);

  pal_state_e             state, state_next;
  logic [PAL_ADDR_W-1:0]  clr_cnt;
  logic [PAL_ENTRY_W-1:0] live   [PAL_ENTRIES];
  logic [PAL_ENTRY_W-1:0] shadow [PAL_ENTRIES];

  logic [PAL_ADDR_W-1:0]  w_canon, r_canon, r_idx;
  logic                   w_alias, r_alias;
  logic                   wr_acc, rd_acc;
  logic [PAL_ENTRY_W-1:0] wr_val;

  palette_mirror_map u_wr_map (.addr(wr_addr), .canon_idx(w_canon), .alias_hit(w_alias));
  palette_mirror_map u_rd_map (.addr(rd_addr), .canon_idx(r_canon), .alias_hit(r_alias));

  assign wr_acc = wr_en && ready && !rst;
  assign rd_acc = rd_en && ready && !rst;
  assign wr_val = {2'b00, wr_data[5:0]};
  assign r_idx  = r_alias ? r_canon : rd_addr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes same-cycle read-before-write
  // and the pre-write shadow copy fall out naturally.
  always_ff @(posedge clk) begin
    if (rst) state <= PAL_INIT;
    else     state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      PAL_INIT: if (clr_cnt == 5'd31) state_next = PAL_IDLE;
      PAL_IDLE: ready = 1'b1;
      default:  state_next = PAL_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                   clr_cnt <= '0;
    else if (state == PAL_INIT) clr_cnt <= clr_cnt + 5'd1;
  end

  // NOTE: the live array has no reset; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == PAL_INIT) begin
        live[clr_cnt] <= INIT_VALUE;
      end else if (wr_acc) begin
        live[w_canon] <= wr_val;
        if (w_alias) live[w_canon | 5'h10] <= wr_val;
      end
    end
  end

  // The shadow must come up valid on the buses, so unlike the live array it is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_ENTRIES; i++) shadow[i] <= INIT_VALUE;
    end else if (frame_sync && (state == PAL_IDLE)) begin
      shadow <= live;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ack   <= wr_acc;
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= live[r_idx];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_bus
    assign background_colors[8*i +: 8] = shadow[i];
    assign sprite_colors[8*i +: 8]     = shadow[16+i];
  end

endmodule

// File: tb/tb_ppu_palette_ram.sv
// Randomised scoreboard bench for ppu_palette_ram against an array-level
// model of the palette (canonical storage, pre-write reads and snapshots).
module tb_ppu_palette_ram;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0, rd_en = 1'b0, frame_sync = 1'b0;
  logic [4:0]   wr_addr = '0, rd_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         wr_ack, rd_valid, ready;
  logic [7:0]   rd_data;
  logic [127:0] background_colors, sprite_colors;

  ppu_palette_ram dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_sync(frame_sync), .ready(ready),
    .background_colors(background_colors), .sprite_colors(sprite_colors)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model stores each distinct palette slot once, indexed by canonical address.
  logic [7:0] m_live   [32];
  logic [7:0] m_shadow [32];
  bit         model_ready  = 0;
  bit         exp_wr_ack   = 0;
  bit         exp_rd_valid = 0;
  logic [7:0] rd_q[$];

  function automatic int canon(int a);
    return (a >= 16 && (a % 4) == 0) ? a - 16 : a;
  endfunction

  function automatic logic [127:0] exp_bus(int base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m_shadow[canon(base + i)];
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_live[i]   = 8'h0F;
      m_shadow[i] = 8'h0F;
    end
    model_ready = 0;
  endtask

  // One clock cycle of stimulus; the model is advanced at the same edge.
  task automatic cyc(bit we, int wa, logic [7:0] wd, bit re, int ra, bit fs);
    logic [4:0] wa5, ra5;
    wa5 = wa[4:0];
    ra5 = ra[4:0];
    wr_en = we; wr_addr = wa5; wr_data = wd;
    rd_en = re; rd_addr = ra5; frame_sync = fs;
    @(posedge clk);
    if (rst) begin
      model_reset();
      exp_wr_ack   = 0;
      exp_rd_valid = 0;
    end else begin
      exp_wr_ack   = we && model_ready;
      exp_rd_valid = re && model_ready;
      if (model_ready) begin
        if (re) rd_q.push_back(m_live[canon(ra)]);
        if (fs) m_shadow = m_live;
        if (we) m_live[canon(wa)] = {2'b00, wd[5:0]};
      end
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0, 0);
  endtask

  // Releases reset and counts cycles until ready; a write/read/frame_sync
  // is injected during the clear and must be dropped.
  task automatic release_and_wait(string name);
    int n;
    n = 0;
    rst = 1'b0;
    while (n < 64) begin
      cyc(n == 4, 3, 8'h22, n == 4, 3, n == 4);
      n++;
      if (n == 32) model_ready = 1;
      if (ready === 1'b1) break;
    end
    check(name, 128'(n), 128'd32);
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each rd_valid.
  always @(negedge clk) begin
    check("ready", ready, model_ready);
    check("wr_ack", wr_ack, exp_wr_ack);
    check("rd_valid", rd_valid, exp_rd_valid);
    check("bg_bus", background_colors, exp_bus(0));
    check("spr_bus", sprite_colors, exp_bus(16));
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_valid with data %0h expected no response", rd_data);
      end else begin
        check("rd_data", rd_data, rd_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    idle(3);
    check("rst_ready", ready, 1'b0);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_bg", background_colors, {16{8'h0F}});
    check("rst_spr", sprite_colors, {16{8'h0F}});

    release_and_wait("ready_latency");

    for (int a = 0; a < 32; a++) cyc(0, 0, 8'h00, 1, a, 0);
    idle(1);

    // Masking of bits 7:6
    cyc(1, 5, 8'hFF, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 5, 0);
    check("masked_read", rd_data, 8'h3F);

    // Mirroring
    cyc(1, 5'h14, 8'h21, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 5'h04, 0);
    check("mirror_rd_04", rd_data, 8'h21);
    cyc(0, 0, 8'h00, 1, 5'h14, 0);
    check("mirror_rd_14", rd_data, 8'h21);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("mirror_bg", background_colors[39:32], 8'h21);
    check("mirror_spr", sprite_colors[39:32], 8'h21);

    // Same-cycle read and write: read sees the old value
    cyc(1, 5'h08, 8'h2A, 1, 5'h08, 0);
    check("rw_same_old", rd_data, 8'h0F);
    cyc(0, 0, 8'h00, 1, 5'h08, 0);
    check("rw_same_new", rd_data, 8'h2A);

    // Shadow only follows frame_sync
    cyc(1, 0, 8'h30, 0, 0, 0);
    idle(2);
    check("shadow_hold", background_colors[7:0], 8'h0F);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("shadow_update", background_colors[7:0], 8'h30);

    // Write coincident with frame_sync waits for the next one
    cyc(1, 1, 8'h12, 0, 0, 1);
    idle(1);
    check("fs_same_cycle", background_colors[15:8], 8'h0F);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("fs_next", background_colors[15:8], 8'h12);

    // Randomised traffic, including back-to-back reads
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), 8'($urandom),
          $urandom_range(0, 2) != 0, int'($urandom_range(0, 31)),
          $urandom_range(0, 7) == 0);
    end
    idle(2);

    // Reset in the middle of the clear sequence
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    rst = 1'b1;
    idle(1);
    release_and_wait("ready_after_mid_init_rst");
    cyc(0, 0, 8'h00, 1, 3, 0);
    check("dropped_init_write", rd_data, 8'h0F);
    for (int a = 0; a < 32; a++) cyc(0, 0, 8'h00, 1, a, 0);
    idle(3);

    check("scoreboard_empty", 128'(rd_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_palette_ram.md
# ppu_palette_ram

Palette memory for the PPU: stores the 32 palette entries addressed by CPU accesses to $3F00–$3F1F and presents them as two packed 128-bit buses, one for background palettes and one for sprite palettes. It is the producer of the palette buses consumed by the colour-selection logic inside ppu_vram_load. CPU-side writes land in a live array. The output buses come from a shadow copy that is refreshed only on a frame-sync strobe, so the pixel pipeline never sees a palette change mid-frame. After reset, a clear sequencer initialises every entry.

## Interface
- INIT_VALUE, 8'h0F: value loaded into every entry by the clear sequence (NES black).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request; honoured only when ready=1.
- wr_addr  in  5  palette address ($3F00 offset, bits 4:0).
- wr_data  in  8  colour value; bits 7:6 are discarded.
- wr_ack  out  1  one-cycle pulse, the cycle after an accepted write.
- rd_en  in  1  read request; honoured only when ready=1.
- rd_addr  in  5  palette address for readback.
- rd_data  out  8  readback value, bits 7:6 = 0; held until the next accepted read.
- rd_valid  out  1  one-cycle pulse, the cycle after an accepted read.
- frame_sync  in  1  one-cycle strobe (vblank start); copies the live array to the shadow.
- ready  out  1  high in IDLE state; low during the clear sequence.
- background_colors  out  128  shadow entries 0–15; entry i at bits [8i+:8].
- sprite_colors  out  128  shadow entries 16–31; entry 16+i at bits [8i+:8].

## Operation
- FSM states:
  - INIT: a 5-bit clear counter walks 0..31, writing INIT_VALUE into the live entry at the counter index, one entry per cycle. INIT moves to IDLE after the entry-31 write.
  - IDLE: accepts reads and writes.
- Mirroring:
  - Addresses 0x10, 0x14, 0x18 and 0x1C alias 0x00, 0x04, 0x08 and 0x0C respectively.
  - A write to either address of an aliased pair updates both live entries in the same cycle.
  - A read of either address of a pair returns the same value.
- Storage width: entries are stored as {2'b00, data[5:0]}.
- Write:
  - Accepted when wr_en & ready; the live entry updates at that clock edge.
  - wr_ack=1 on the following cycle.
  - A write while ready=0 is dropped: no state change, no wr_ack.
- Read:
  - Accepted when rd_en & ready; rd_data and rd_valid=1 appear the following cycle.
  - A read while ready=0 is dropped.
- Simultaneous read and write to the same (or aliased) address: the read returns the pre-write value.
- frame_sync:
  - On the strobe cycle the shadow takes a copy of the live array as it stands before that edge's write.
  - A write accepted in the same cycle therefore appears only after the next frame_sync.
  - frame_sync during INIT is ignored; the shadow keeps its reset value.
- Reset: rst asserted in any state, including mid-INIT, returns the FSM to INIT with the counter at 0.

## Timing
- Reset values:
  - ready=0, wr_ack=0, rd_valid=0, rd_data=8'h00.
  - background_colors and sprite_colors = INIT_VALUE replicated 16×.
  - Clear counter = 0.
- Clear sequence: the first rising edge with rst=0 performs the clear write for index 0. Index 31 is written on the 32nd such edge. ready=1 from the following cycle, i.e. 32 cycles after reset release.
- Write latency: 1 cycle to wr_ack. A write is visible on the output buses on the cycle after the next frame_sync edge.
- Read latency: 1 cycle. Back-to-back reads are allowed every cycle.
- Output buses change only on the cycle following a frame_sync edge, or on reset.

## Structure
- Shared package ppu_pkg:
  - PAL_ENTRIES=32, PAL_ENTRY_W=8.
  - The mirror-canonicalisation function: if addr[4] and addr[1:0]==0, clear bit 4.
  - FSM state encoding {PAL_INIT, PAL_IDLE}.
- One sub-module, palette_mirror_map: combinational mapping of a 5-bit address to the canonical index plus an alias-hit flag. It is instantiated once for the write port and once for the read port.
- Live and shadow arrays are plain register arrays; there is no block RAM, because the shadow needs a full-width parallel copy.

## Test plan
- Reset release:
  - Release rst, count cycles → ready rises exactly 32 cycles later.
  - Read all 32 addresses → every rd_data=8'h0F.
  - Buses = {16{8'h0F}} throughout.
- Write/readback with masking: write 0x05=8'hFF → wr_ack next cycle; read 0x05 → rd_data=8'h3F.
- Mirroring:
  - Write 0x14=8'h21 → reads of 0x04 and 0x14 both return 8'h21.
  - After frame_sync → background_colors[39:32]=8'h21 and sprite_colors[39:32]=8'h21.
- Shadow timing:
  - Write 0x00=8'h30 → background_colors[7:0] stays 8'h0F until frame_sync, becomes 8'h30 the cycle after.
  - Write 0x01=8'h12 in the same cycle as frame_sync → bus keeps the old value until the next frame_sync.
- Same-cycle read and write: entry 0x08=8'h0F; read 0x08 and write 0x08=8'h2A together → rd_data=8'h0F; a subsequent read → 8'h2A.
- Mid-INIT behaviour:
  - Assert rst at clear index 10 → sequence restarts; ready rises 32 cycles after release.
  - wr_en issued while ready=0 → no wr_ack, and the entry remains 8'h0F.
